// File: rtl/reg_bank_dump_if.sv
// Bundle that links the dump sequencer to the debug unit, the bank debug read port and the byte TX unit.
// The master modport is the sequencer. The slave modport is the surrounding debug/bank/TX logic.
interface reg_bank_dump_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic [7:0]            o_tx_data;
  logic                  o_tx_start;
  logic                  i_tx_busy;
  logic                  i_tx_done;
  logic                  o_busy;
  logic                  o_done;

  // Handshake to TX: o_tx_start is a one-cycle pulse that is only raised while i_tx_busy is low,
  // and o_tx_data is valid with it and holds afterwards. i_tx_done is a one-cycle pulse. It is
  // honoured only after the start pulse has dropped.
  modport master (
    input  i_start, i_rd_data, i_tx_busy, i_tx_done,
    output o_rd_addr, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport slave (
    output i_start, i_rd_data, i_tx_busy, i_tx_done,
    input  o_rd_addr, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/reg_bank_dump_ctrl.sv
// Walks registers 0..NUM_REGS-1 through the bank debug read port.
// It serialises each word MSB byte first to the byte-wide TX unit. All outputs are registered.
module reg_bank_dump_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  reg_bank_dump_if.master   bus,
  output logic [2:0]        dbg_state
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BCW-1:0]        bytecnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [7:0]            tx_data_q;
  logic                  tx_start_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      bytecnt    <= '0;
      shreg      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            addr_q <= '0;
            busy_q <= 1'b1;
            state  <= READ;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          shreg   <= bus.i_rd_data;
          bytecnt <= '0;
          state   <= SEND;
        end
        SEND: begin
          if (!bus.i_tx_busy) begin
            tx_data_q  <= shreg[DATA_WIDTH-1 -: 8];
            tx_start_q <= 1'b1;
            state      <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // A done pulse that coincides with our own start pulse belongs to an earlier byte.
          if (bus.i_tx_done && !tx_start_q) begin
            if (bytecnt == LAST_BYTE) begin
              state <= NEXT;
            end else begin
              shreg   <= shreg << 8;
              bytecnt <= bytecnt + BCW'(1);
              state   <= SEND;
            end
          end
        end
        NEXT: begin
          if (addr_q == LAST_ADDR) begin
            state <= DONE;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            state  <= READ;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_rd_addr  = addr_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_reg_bank_dump_ctrl.sv
// Randomised bench for reg_bank_dump_ctrl. It runs a 32x32 instance and a small 4x16 instance.
// Expected byte streams and timing gaps come from the register contents and the dump rules.
module tb_reg_bank_dump_ctrl;
  localparam int DW = 32, NR = 32, AW = 5, BYTES = DW / 8;
  localparam int DW2 = 16, NR2 = 4, AW2 = 2, BYTES2 = DW2 / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- clock/reset, DUT, bank model ----------------
  reg_bank_dump_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [2:0] dbg_state;
  reg_bank_dump_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus), .dbg_state(dbg_state));

  logic [DW-1:0] bank [NR];
  logic tx_busy_m = 1'b0, tx_done_m = 1'b0, hold_busy = 1'b0, spur_done = 1'b0;
  logic same_inj = 1'b0;
  int   fixed_lat = 4;
  logic chk_first = 1'b1;
  logic [7:0] exp_q[$];

  assign bus.i_rd_data = bank[bus.o_rd_addr];
  assign bus.i_tx_busy = tx_busy_m | hold_busy;
  assign bus.i_tx_done = tx_done_m | spur_done;

  // TX model: busy from start until done, done arrives lat cycles after the start pulse
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #2;
      tx_done_m = 1'b0;
      if (rst) begin
        tx_busy_m = 1'b0;
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done_m = 1'b1;
          tx_busy_m = 1'b0;
        end
      end else if (bus.o_tx_start) begin
        tx_busy_m = 1'b1;
        tx_done_m = same_inj;
        cnt = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    int cyc = 0, last_done = 0, start_cyc = 0, pos = 0;
    logic prev_busy = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pos = 0;
        prev_busy = 1'b0;
        continue;
      end
      if (bus.o_tx_start) begin
        chk("start_while_tx_busy", 64'(prev_busy), 0);
        chk("o_busy_during_dump", 64'(bus.o_busy), 1);
        if (pos == 0) begin
          if (chk_first) chk("first_byte_latency", 64'(cyc - start_cyc), 4);
        end else begin
          chk("byte_gap", 64'(cyc - last_done), (pos % BYTES == 0) ? 64'd5 : 64'd2);
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte act=%0h exp=none", bus.o_tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 64'(bus.o_tx_data), 64'(e));
        end
        pos++;
      end else if (bus.i_tx_done) begin
        last_done = cyc;
      end
      if (bus.o_done) begin
        chk("done_gap", 64'(cyc - last_done), 3);
        chk("done_queue_empty", 64'(exp_q.size()), 0);
        chk("busy_low_at_done", 64'(bus.o_busy), 0);
        chk("rd_addr_last", 64'(bus.o_rd_addr), NR - 1);
        pos = 0;
      end
      if (bus.i_start && !bus.o_busy) begin
        start_cyc = cyc;
        pos = 0;
      end
      prev_busy = bus.i_tx_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_dump();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < BYTES; j++)
        exp_q.push_back(8'(bank[k] >> (8 * (BYTES - 1 - j))));
  endtask

  task automatic do_start(input logic expect_dump);
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    if (expect_dump) push_dump();
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
    end
    chk(name, 64'(seen), 1);
  endtask

  task automatic wait_addr(input int a, input logic need_start, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_rd_addr == AW'(a) && (!need_start || bus.o_tx_start)) seen = 1'b1;
    end
    chk(name, 64'(seen), 1);
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, 64'({bus.o_rd_addr, bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_done}), 0);
  endtask

  // ---------------- second instance: 4 registers of 16 bits ----------------
  reg_bank_dump_if #(.DATA_WIDTH(DW2), .ADDR_WIDTH(AW2)) bus2 ();
  logic [2:0] dbg_state2;
  reg_bank_dump_ctrl #(.DATA_WIDTH(DW2), .NUM_REGS(NR2), .ADDR_WIDTH(AW2)) dut2 (
    .i_clock(clk), .i_reset(rst2), .bus(bus2), .dbg_state(dbg_state2));

  logic [DW2-1:0] bank2 [NR2];
  logic tx_busy2 = 1'b0, tx_done2 = 1'b0, fin2 = 1'b0;
  logic [7:0] exp2_q[$];
  assign bus2.i_rd_data = bank2[bus2.o_rd_addr];
  assign bus2.i_tx_busy = tx_busy2;
  assign bus2.i_tx_done = tx_done2;

  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #2;
      tx_done2 = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done2 = 1'b1;
          tx_busy2 = 1'b0;
        end
      end else if (bus2.o_tx_start) begin
        tx_busy2 = 1'b1;
        cnt = 3;
      end
    end
  end

  initial begin
    int cyc = 0, last_done = 0, nbytes = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus2.o_tx_start) begin
        nbytes++;
        if (exp2_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL small_unexpected_byte act=%0h exp=none", bus2.o_tx_data);
        end else begin
          e = exp2_q.pop_front();
          chk("small_tx_byte", 64'(bus2.o_tx_data), 64'(e));
        end
      end else if (bus2.i_tx_done) begin
        last_done = cyc;
      end
      if (bus2.o_done) begin
        chk("small_byte_count", 64'(nbytes), NR2 * BYTES2);
        chk("small_done_gap", 64'(cyc - last_done), 3);
        chk("small_rd_addr_last", 64'(bus2.o_rd_addr), NR2 - 1);
      end
    end
  end

  initial begin
    logic seen = 1'b0;
    bus2.i_start = 1'b0;
    for (int k = 0; k < NR2; k++) bank2[k] = 16'(32'h1234 + 32'h0101 * k + $urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
    @(posedge clk); #1;
    bus2.i_start = 1'b1;
    for (int k = 0; k < NR2; k++)
      for (int j = 0; j < BYTES2; j++)
        exp2_q.push_back(8'(bank2[k] >> (8 * (BYTES2 - 1 - j))));
    @(posedge clk); #1;
    bus2.i_start = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (bus2.o_done) seen = 1'b1;
    end
    chk("small_dump_done", 64'(seen), 1);
    @(negedge clk);
    chk("small_busy_after", 64'(bus2.o_busy), 0);
    fin2 = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.i_start = 1'b0;
    for (int k = 0; k < NR; k++) bank[k] = 32'hA0B0C0D0 + 32'(k);

    // reset, then idle with stray done pulses
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_outs_zero("reset_outputs");
    chk("reset_state", 64'(dbg_state), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      spur_done = 1'(i % 2);
      @(negedge clk);
      chk_outs_zero("idle_outputs");
    end
    @(posedge clk); #1 spur_done = 1'b0;

    // full dump, TX done 4 cycles after start
    do_start(1'b1);
    wait_done("dump_fixed_done");
    @(negedge clk);
    chk("busy_after_dump", 64'(bus.o_busy), 0);
    chk("rd_addr_holds", 64'(bus.o_rd_addr), NR - 1);

    // TX busy held across the first SEND
    hold_busy = 1'b1;
    chk_first = 1'b0;
    do_start(1'b1);
    repeat (20) @(posedge clk);
    #1 hold_busy = 1'b0;
    wait_done("dump_hold_done");
    chk_first = 1'b1;

    // random TX latency, stray done with each start pulse, restart attempt mid-dump
    fixed_lat = 0;
    same_inj = 1'b1;
    for (int k = 0; k < NR; k++) bank[k] = $urandom;
    do_start(1'b1);
    wait_addr(5, 1'b0, "reach_reg5");
    do_start(1'b0);
    wait_done("dump_restart_done");
    same_inj = 1'b0;

    // reset while waiting on TX for register 7, then a fresh dump
    do_start(1'b1);
    wait_addr(7, 1'b1, "reach_reg7");
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk_outs_zero("midreset_outputs");
    chk("midreset_state", 64'(dbg_state), 0);
    repeat (3) @(posedge clk);
    for (int k = 0; k < NR; k++) bank[k] = $urandom;
    do_start(1'b1);
    wait_done("dump_after_reset_done");

    for (int i = 0; i < 2000 && !fin2; i++) @(posedge clk);
    chk("small_instance_finished", 64'(fin2), 1);
    chk("leftover_bytes", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
